// File: rtl/fc_score_pkg.sv
// fc_score_pkg: shared FSM encoding, csel codes, and Q4.16 sizing for the FC score stage
package fc_score_pkg;
  localparam int N_FEAT = 2048;
  localparam int N_OUT = 2;
  localparam int DATA_W = 20;
  localparam int ACC_W = 52;
  localparam int FRAC = 16;
  localparam int O_W = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam logic [2:0] SEL_IN = 3'd5;
  localparam logic [2:0] SEL_OUT = 3'd6;
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, BIAS, WRITE, DONE} state_t;
endpackage

// File: rtl/fc_score_if.sv
// fc_score_if: start/status, feature read, weight ROM and score write signals; slave = fc_score, master = driver
interface fc_score_if;
  import fc_score_pkg::*;
  logic start, busy, done, crd, cwr, class_idx;
  logic [11:0] caddr_rd, caddr_wr;
  logic [12:0] waddr;
  logic signed [DATA_W-1:0] cdata_rd, wdata, cdata_wr;
  logic [2:0] csel;
  modport master (output start, cdata_rd, wdata,
                  input busy, done, crd, cwr, class_idx, caddr_rd, caddr_wr, waddr, cdata_wr, csel);
  modport slave (input start, cdata_rd, wdata,
                 output busy, done, crd, cwr, class_idx, caddr_rd, caddr_wr, waddr, cdata_wr, csel);
endinterface

// File: rtl/fc_score_mac.sv
// fc_mac: signed multiply-accumulate with clear/add/bias controls; score = sat20((acc + 2^15) >>> 16)
module fc_mac import fc_score_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic add,
  input  logic bias,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] score
);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;
  logic signed [ACC_W-1:0] acc, rnd;
  logic signed [2*DATA_W-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (clear) acc <= '0;
    else if (add) acc <= acc + ACC_W'(prod);
    else if (bias) acc <= acc + (ACC_W'(b) <<< FRAC);
  assign rnd = (acc + (ACC_W'(1) <<< (FRAC - 1))) >>> FRAC;
  assign score = rnd > SMAX ? DATA_W'(SMAX) : rnd < SMIN ? DATA_W'(SMIN) : rnd[DATA_W-1:0];
endmodule

// File: rtl/fc_score.sv
// fc_score: FC output stage, N_OUT dot products + bias, rounded/saturated scores and argmax class
module fc_score import fc_score_pkg::*; (
  input logic clk,
  input logic reset,
  fc_score_if.slave bus
);
  state_t state, nxt;
  logic [11:0] i;
  logic [O_W-1:0] o;
  logic signed [DATA_W-1:0] best, score;
  logic [O_W-1:0] cls;
  fc_mac u_mac (
    .clk(clk), .reset(reset),
    .clear(state == CLEAR), .add(state == MAC), .bias(state == BIAS),
    .a(bus.cdata_rd), .b(bus.wdata), .score(score)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (bus.start ? CLEAR : IDLE) :
          state == CLEAR ? MAC :
          state == MAC   ? (i == 12'(N_FEAT - 1) ? BIAS : MAC) :
          state == BIAS  ? WRITE :
          state == WRITE ? (o == O_W'(N_OUT - 1) ? DONE : CLEAR) : IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      i <= '0;
      o <= '0;
      best <= '0;
      cls <= '0;
    end else begin
      i <= state == CLEAR ? 12'd0 : state == MAC ? i + 12'd1 : i;
      o <= state == IDLE ? '0 : state == WRITE ? o + 1'b1 : o;
      // strict '>' keeps the lower index on ties
      if (state == WRITE && (o == '0 || score > best)) begin
        best <= score;
        cls <= o;
      end
    end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.crd = state == MAC;
    bus.cwr = state == WRITE;
    bus.caddr_rd = state == MAC ? i : 12'd0;
    bus.waddr = state == MAC  ? 13'(o) * 13'(N_FEAT) + 13'(i) :
                state == BIAS ? 13'(N_OUT * N_FEAT) + 13'(o) : 13'd0;
    bus.caddr_wr = state == WRITE ? 12'(o) : 12'd0;
    bus.cdata_wr = state == WRITE ? score : '0;
    bus.csel = state == MAC ? SEL_IN : state == WRITE ? SEL_OUT : 3'd0;
    bus.class_idx = cls[0];
  end
endmodule

// File: tb/tb_fc_score.sv
// tb_fc_score: table-driven runs with a score scoreboard, plus restart-suppression and mid-run reset sequences
module tb_fc_score;
  import fc_score_pkg::*;
  typedef struct {
    logic [19:0] fv;
    bit f0_only;
    logic [19:0] wv, b0, b1, e0, e1;
    logic cls;
  } vec_t;
  typedef struct {
    logic [11:0] addr;
    logic [19:0] data;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  logic [19:0] feat[4096];
  logic [19:0] wrom[8192];
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  vec_t v[8];
  fc_score_if bus();
  fc_score dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.cdata_rd = feat[bus.caddr_rd];
  assign bus.wdata = wrom[bus.waddr];
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (bus.cwr === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_cwr: addr %0h data %0h", bus.caddr_wr, bus.cdata_wr);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("score_addr", 20'(bus.caddr_wr), 20'(e.addr));
        check("score_data", bus.cdata_wr, e.data);
        check("score_csel", 20'(bus.csel), 20'(SEL_OUT));
      end
    end
  task automatic load(input vec_t x);
    for (int k = 0; k < 4096; k++)
      feat[k] = x.f0_only ? (k == 0 ? x.fv : 20'd0) : (k < N_FEAT ? x.fv : 20'd0);
    for (int k = 0; k < 8192; k++) wrom[k] = k < N_OUT * N_FEAT ? x.wv : 20'd0;
    wrom[N_OUT * N_FEAT] = x.b0;
    wrom[N_OUT * N_FEAT + 1] = x.b1;
    q.push_back('{12'd0, x.e0});
    q.push_back('{12'd1, x.e1});
  endtask
  task automatic pulse_start;
    @(negedge clk) bus.start = 1;
    @(posedge clk) #1 bus.start = 0;
  endtask
  task automatic run(input vec_t x);
    int cyc;
    load(x);
    pulse_start();
    cyc = 0;
    do begin
      @(negedge clk) cyc++;
      if (cyc == 1) check("busy_after_start", 20'(bus.busy), 20'd1);
      if (cyc == 5) check("csel_mac", 20'(bus.csel), 20'(SEL_IN));
    end while (bus.done !== 1'b1 && cyc < 5000);
    check("done_latency", 20'(cyc), 20'd4103);
    check("class_idx", 20'(bus.class_idx), 20'(x.cls));
    check("queue_drained", 20'(q.size()), 20'd0);
    q.delete();
    @(negedge clk) check("idle_after_done", 20'(bus.busy), 20'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int ndone;
    v[0] = '{20'h10000, 1'b0, 20'h00040, 20'h0, 20'h0, 20'h20000, 20'h20000, 1'b0};
    v[1] = '{20'h10000, 1'b0, 20'h00100, 20'h0, 20'h0, 20'h7FFFF, 20'h7FFFF, 1'b0};
    v[2] = '{20'h10000, 1'b0, 20'hF0000, 20'h0, 20'h0, 20'h80000, 20'h80000, 1'b0};
    v[3] = '{20'h00001, 1'b1, 20'h08000, 20'h0, 20'h0, 20'h00001, 20'h00001, 1'b0};
    v[4] = '{20'h00001, 1'b1, 20'h07FFF, 20'h0, 20'h0, 20'h00000, 20'h00000, 1'b0};
    v[5] = '{20'h00001, 1'b1, 20'hF8000, 20'h0, 20'h0, 20'h00000, 20'h00000, 1'b0};
    v[6] = '{20'h00000, 1'b0, 20'h00000, 20'h00010, 20'h00020, 20'h00010, 20'h00020, 1'b1};
    v[7] = '{20'h00000, 1'b0, 20'h00000, 20'hFFFF0, 20'hFFFE0, 20'hFFFF0, 20'hFFFE0, 1'b0};
    bus.start = 0;
    for (int k = 0; k < 4096; k++) feat[k] = 0;
    for (int k = 0; k < 8192; k++) wrom[k] = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", 20'(bus.busy), 20'd0);
    check("reset_done", 20'(bus.done), 20'd0);
    check("reset_csel", 20'(bus.csel), 20'd0);
    check("reset_class", 20'(bus.class_idx), 20'd0);
    reset = 1;
    @(negedge clk);
    for (int n = 0; n < 8; n++) run(v[n]);
    // start pulses during MAC and during DONE must not restart the run
    load(v[0]);
    pulse_start();
    ndone = 0;
    for (int k = 1; k <= 4140; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        check("done_latency_ignore", 20'(k), 20'd4103);
      end
      bus.start = (k == 100) || (bus.done === 1'b1);
    end
    bus.start = 0;
    check("single_done", 20'(ndone), 20'd1);
    check("no_restart_busy", 20'(bus.busy), 20'd0);
    check("queue_drained_ignore", 20'(q.size()), 20'd0);
    q.delete();
    // reset in the middle of neuron 1's MAC phase
    load(v[0]);
    pulse_start();
    repeat (N_FEAT + 3 + 100) @(negedge clk);
    check("pre_reset_crd", 20'(bus.crd), 20'd1);
    #2 reset = 0;
    #1;
    check("rst_busy", 20'(bus.busy), 20'd0);
    check("rst_crd", 20'(bus.crd), 20'd0);
    check("rst_cwr", 20'(bus.cwr), 20'd0);
    check("rst_csel", 20'(bus.csel), 20'd0);
    check("rst_caddr_rd", 20'(bus.caddr_rd), 20'd0);
    check("rst_waddr", 20'(bus.waddr), 20'd0);
    check("rst_cdata_wr", bus.cdata_wr, 20'd0);
    check("rst_class", 20'(bus.class_idx), 20'd0);
    check("rst_pending_scores", 20'(q.size()), 20'd1);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    run(v[6]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
